// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the control unit and the multi-cycle shifter.
// The control unit holds the master side and stalls while busy is high.
interface shift_sequencer_if #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   out;

    modport master (
        output start, op, in, shamt,
        input  busy, done, out
    );

    modport slave (
        input  start, op, in, shamt,
        output busy, done, out
    );
endinterface

// File: rtl/shift_sequencer.sv
// Serial shift engine: captures one request in IDLE, shifts the operand one bit
// per clock in SHIFT, then raises done for a single cycle in DONE.
module shift_sequencer #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_start;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] shifted;
    logic             accept;

    assign accept = (state == IDLE) && bus.start;

    // Linear shifts saturate at WIDTH steps; a rotate only needs the residue.
    always_comb begin
        count_start = '0;
        if (bus.op == OP_ROR) begin
            count_start = CNT_W'(32'(bus.shamt) % WIDTH);
        end else if (32'(bus.shamt) >= WIDTH) begin
            count_start = CNT_W'(WIDTH);
        end else begin
            count_start = CNT_W'(bus.shamt);
        end
    end

    always_comb begin
        shifted = bus.out;
        case (op_q)
            OP_SLL:  shifted = {bus.out[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, bus.out[WIDTH-1:1]};
            OP_SRA:  shifted = {bus.out[WIDTH-1], bus.out[WIDTH-1:1]};
            OP_ROR:  shifted = {bus.out[0], bus.out[WIDTH-1:1]};
            default: shifted = bus.out;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (count_start == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count <= CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // busy/done are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out  <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            count    <= '0;
            op_q     <= OP_SLL;
        end else begin
            bus.busy <= (state_next != IDLE);
            bus.done <= (state_next == DONE);
            if (accept) begin
                bus.out <= bus.in;
                op_q    <= bus.op;
                count   <= count_start;
            end else if (state == SHIFT) begin
                bus.out <= shifted;
                count   <= count - CNT_W'(1);
            end
        end
    end
endmodule
